csr_layer_controller_param: RTL and testbench
=============================================

Name: csr_layer_controller_param

Overview:
- Parametrised successor to the first-layer CSR controller state machine.
- Sequences one SNN layer over a configurable number of timesteps:
  - initialises every neuron's membrane voltage;
  - for each timestep, walks each neuron's CSR weight row using a cumulative row-end offset memory;
  - issues weight/activation-valid, load and export strobes to the IF neuron datapath and voltage memory.
- Sits between the pre-processing stage (start) and the offset / weight / voltage memories and the acc_encapsule_IF neuron.

Parameters:
- N_NEURONS, 64, neurons in the layer; row index 0..N_NEURONS-1.
- NEUR_W, $clog2(N_NEURONS), neuron / voltage-memory address width.
- OFFSET_W, 10, width of a cumulative row-end value.
- W_ADDR_W, 14, CSR weight address width (must be >= OFFSET_W).
- VOL_W, 16, membrane voltage width.
- STEP_W, 8, timestep counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse from pre-processing.
- num_steps  in  STEP_W  timesteps to run; latched on accepted start.
- init_vol  in  VOL_W  initial membrane voltage; latched on accepted start.
- off_set_value  in  OFFSET_W  offset memory read data; 1-cycle read latency.
- offset_mem_addr  out  NEUR_W  current neuron index; shared with voltage memory address.
- CSR_w_addr  out  W_ADDR_W  weight memory address.
- w_n_a_valid  out  1  CSR_w_addr valid this cycle.
- load_voltage  out  1  neuron loads voltage of offset_mem_addr.
- export_voltage  out  1  neuron exports processed voltage.
- vol_mem_control  out  1  init write enable to voltage memory.
- init_mem_vol  out  VOL_W  init write data.
- current_step_finished  out  1  pulse at the end of each timestep.
- step_idx  out  STEP_W  current timestep.
- busy  out  1  high from accepted start until DONE is left.
- all_done  out  1  one-cycle pulse after the last timestep.
- csr_err  out  1  sticky; set on a malformed offset.

Behaviour:
- Reset (rst high at a clock edge, in any state, including mid-row): state goes to IDLE; all outputs, counters and pointers go to 0; csr_err is cleared.
- IDLE:
  - start=1 latches num_steps and init_vol, then goes to INIT.
  - start while busy is ignored.
- INIT, one cycle per neuron:
  - vol_mem_control=1, offset_mem_addr=j, init_mem_vol=latched init_vol, for j=0..N_NEURONS-1.
  - Then, if num_steps==0, go to DONE; otherwise clear step_idx and go to FETCH with j=0 and row_start=0.
- FETCH: drive offset_mem_addr=j for one cycle.
- LATCH:
  - Capture row_end <= off_set_value.
  - If off_set_value < row_start: set csr_err and treat the row as empty (row_end := row_start).
- LOAD: one cycle, load_voltage=1, ptr <= row_start. Next state is ROW if row_end > row_start, else EXPORT.
- ROW:
  - Each cycle: w_n_a_valid=1, CSR_w_addr=zero-extended ptr, ptr++.
  - The cycle that issues ptr==row_end-1 is the last ROW cycle; next state is EXPORT.
- EXPORT:
  - One cycle: export_voltage=1, row_start <= row_end.
  - If j==N_NEURONS-1, go to STEP_END; else j++ and go to FETCH.
- STEP_END:
  - One cycle: current_step_finished=1.
  - If step_idx==num_steps-1, go to DONE; else step_idx++, j=0, row_start=0, go to FETCH.
- DONE: one cycle: all_done=1, busy drops the next cycle, then IDLE. A start in the DONE cycle is ignored.
- offset_mem_addr holds j through FETCH..EXPORT so that the voltage memory address is stable.
- Outputs are registered (Moore). Strobes are mutually exclusive.
- Per-neuron latency is nnz+4 cycles. Timestep latency is sum(nnz)+4*N_NEURONS+1 cycles.
- The weight-index/activation path downstream sees w_n_a_valid aligned with CSR_w_addr. Delaying it to align with weight read data is the integrator's job.

Decomposition:
- Package csr_ctrl_pkg:
  - state enum ctrl_state_t {IDLE, INIT, FETCH, LATCH, LOAD, ROW, EXPORT, STEP_END, DONE};
  - default widths as localparams.
- One natural sub-module, csr_row_walker: owns LOAD/ROW/EXPORT, ptr, row_start and row_end. Handshake is row_go, row_end_in, row_done.

Test Plan:
- Reset mid-ROW (assert rst during the 3rd weight of row 1) -> next cycle all outputs 0, busy=0; a fresh start runs INIT from neuron 0.
- N_NEURONS=4, offsets {3,3,7,8}, num_steps=1, init_vol=16'h0100:
  - 4 INIT writes of 0x0100 to addrs 0..3;
  - CSR_w_addr sequence 0,1,2 | none | 3,4,5,6 | 7;
  - row 1 gets load then export with no valid;
  - current_step_finished after 8+16+1=25 cycles from FETCH;
  - all_done one cycle later.
- Same offsets, num_steps=3 -> 3 current_step_finished pulses 25 cycles apart; step_idx 0,1,2; weight sequence repeats from 0 each step.
- num_steps=0 -> INIT only, then all_done; no w_n_a_valid ever.
- Malformed offsets {5,2,6,6} -> csr_err=1 after row 1 LATCH; row 1 empty; row 2 issues addrs 5; csr_err stays 1 until rst.
- start pulsed during ROW and during DONE -> ignored; exactly one all_done per accepted start.

Source files
------------

// File: rtl/csr_ctrl_pkg.sv
// csr_ctrl_pkg
//   Shared types and default widths for the parametrised CSR layer controller.
//   ctrl_state_t names every phase of the layer sequence. The top FSM walks
//   IDLE/INIT/FETCH/LATCH/STEP_END/DONE. The row walker walks LOAD/ROW/EXPORT.
//   The DEF_* localparams are the default parameter values of both modules.
package csr_ctrl_pkg;

  localparam int DEF_N_NEURONS = 64;
  localparam int DEF_OFFSET_W  = 10;
  localparam int DEF_W_ADDR_W  = 14;
  localparam int DEF_VOL_W     = 16;
  localparam int DEF_STEP_W    = 8;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    FETCH,
    LATCH,
    LOAD,
    ROW,
    EXPORT,
    STEP_END,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/csr_row_walker.sv
// csr_row_walker
//   Walks one CSR weight row per handshake. It owns row_start, row_end and the
//   weight pointer, and it sequences LOAD -> ROW* -> EXPORT.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   row_go            pulse from the controller in LATCH; row_end_in is valid
//   row_end_in        cumulative row-end offset for the current neuron
//   row_clear         forces row_start back to 0 (start of a timestep)
//   row_done          high in the EXPORT cycle; the controller advances then
//   err_set           pulse when row_end_in is below row_start (malformed CSR)
//   load_voltage      LOAD strobe
//   w_n_a_valid       ROW strobe; CSR_w_addr is valid in this cycle
//   CSR_w_addr        zero-extended weight pointer while in ROW, else 0
//   export_voltage    EXPORT strobe
module csr_row_walker
  import csr_ctrl_pkg::*;
#(
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int W_ADDR_W = DEF_W_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                row_go,
  input  logic [OFFSET_W-1:0] row_end_in,
  input  logic                row_clear,
  output logic                row_done,
  output logic                err_set,
  output logic                load_voltage,
  output logic                w_n_a_valid,
  output logic [W_ADDR_W-1:0] CSR_w_addr,
  output logic                export_voltage
);

  ctrl_state_t         phase_q, phase_d;
  logic [OFFSET_W-1:0] ptr_q, ptr_d;
  logic [OFFSET_W-1:0] row_start_q, row_start_d;
  logic [OFFSET_W-1:0] row_end_q, row_end_d;

  // A malformed offset (below row_start) is clamped to row_start, so the row
  // is empty and row_start never runs backwards. The last ROW cycle is the
  // one whose pointer is row_end-1. The compare uses ptr+1 so that it cannot
  // underflow.
  always_comb begin
    phase_d     = phase_q;
    ptr_d       = ptr_q;
    row_start_d = row_start_q;
    row_end_d   = row_end_q;
    err_set     = 1'b0;
    case (phase_q)
      IDLE: begin
        if (row_go) begin
          if (row_end_in < row_start_q) begin
            err_set   = 1'b1;
            row_end_d = row_start_q;
          end else begin
            row_end_d = row_end_in;
          end
          phase_d = LOAD;
        end
      end
      LOAD: begin
        ptr_d   = row_start_q;
        phase_d = (row_end_q > row_start_q) ? ROW : EXPORT;
      end
      ROW: begin
        ptr_d = ptr_q + OFFSET_W'(1);
        if (ptr_q + OFFSET_W'(1) == row_end_q) begin
          phase_d = EXPORT;
        end
      end
      EXPORT: begin
        row_start_d = row_end_q;
        phase_d     = IDLE;
      end
      default: phase_d = IDLE;
    endcase
    if (row_clear) begin
      row_start_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= IDLE;
      ptr_q       <= '0;
      row_start_q <= '0;
      row_end_q   <= '0;
    end else begin
      phase_q     <= phase_d;
      ptr_q       <= ptr_d;
      row_start_q <= row_start_d;
      row_end_q   <= row_end_d;
    end
  end

  assign load_voltage   = (phase_q == LOAD);
  assign w_n_a_valid    = (phase_q == ROW);
  assign export_voltage = (phase_q == EXPORT);
  assign row_done       = export_voltage;
  assign CSR_w_addr     = w_n_a_valid ? W_ADDR_W'(ptr_q) : '0;

endmodule

// File: rtl/csr_layer_controller_param.sv
// csr_layer_controller_param
//   Sequences one SNN layer over num_steps timesteps. It first writes
//   init_vol into every neuron's voltage slot. Then, on every timestep, it
//   fetches each neuron's cumulative row-end offset and hands the row to
//   csr_row_walker, which issues load, weight-valid and export strobes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle start pulse; ignored while busy
//   num_steps, init_vol      latched when start is accepted
//   off_set_value            offset memory read data (1-cycle read latency)
//   offset_mem_addr          neuron index; also the voltage memory address
//   CSR_w_addr, w_n_a_valid  weight address and its valid strobe
//   load_voltage             neuron loads its voltage
//   export_voltage           neuron writes back its voltage
//   vol_mem_control          init write enable
//   init_mem_vol             init write data
//   current_step_finished    one-cycle pulse at the end of each timestep
//   step_idx                 current timestep
//   busy                     high from accepted start until DONE is left
//   all_done                 one-cycle pulse after the last timestep
//   csr_err                  sticky malformed-offset flag; cleared only by rst
// All outputs decode registered state only (Moore). The strobes are
// mutually exclusive.
module csr_layer_controller_param
  import csr_ctrl_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int NEUR_W    = $clog2(N_NEURONS),
  parameter int OFFSET_W  = DEF_OFFSET_W,
  parameter int W_ADDR_W  = DEF_W_ADDR_W,
  parameter int VOL_W     = DEF_VOL_W,
  parameter int STEP_W    = DEF_STEP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [STEP_W-1:0]   num_steps,
  input  logic [VOL_W-1:0]    init_vol,
  input  logic [OFFSET_W-1:0] off_set_value,
  output logic [NEUR_W-1:0]   offset_mem_addr,
  output logic [W_ADDR_W-1:0] CSR_w_addr,
  output logic                w_n_a_valid,
  output logic                load_voltage,
  output logic                export_voltage,
  output logic                vol_mem_control,
  output logic [VOL_W-1:0]    init_mem_vol,
  output logic                current_step_finished,
  output logic [STEP_W-1:0]   step_idx,
  output logic                busy,
  output logic                all_done,
  output logic                csr_err
);

  localparam logic [NEUR_W-1:0] LAST_J = NEUR_W'(N_NEURONS - 1);

  ctrl_state_t       state_q, state_d;
  logic [NEUR_W-1:0] j_q, j_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] num_steps_q, num_steps_d;
  logic [VOL_W-1:0]  init_vol_q, init_vol_d;
  logic              csr_err_q, csr_err_d;
  logic              row_go, row_clear, row_done, err_set;

  // The walker owns LOAD/ROW/EXPORT. This FSM parks in LOAD for the whole
  // row and advances on row_done (the EXPORT cycle), which keeps j, and so
  // the voltage memory address, stable from FETCH through EXPORT.
  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    step_d      = step_q;
    num_steps_d = num_steps_q;
    init_vol_d  = init_vol_q;
    csr_err_d   = csr_err_q | err_set;
    row_go      = 1'b0;
    row_clear   = (state_q == IDLE) || (state_q == INIT) || (state_q == STEP_END);
    case (state_q)
      IDLE: begin
        if (start) begin
          num_steps_d = num_steps;
          init_vol_d  = init_vol;
          step_d      = '0;
          j_d         = '0;
          state_d     = INIT;
        end
      end
      INIT: begin
        if (j_q == LAST_J) begin
          j_d     = '0;
          step_d  = '0;
          state_d = (num_steps_q == '0) ? DONE : FETCH;
        end else begin
          j_d = j_q + NEUR_W'(1);
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        row_go  = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        if (row_done) begin
          if (j_q == LAST_J) begin
            state_d = STEP_END;
          end else begin
            j_d     = j_q + NEUR_W'(1);
            state_d = FETCH;
          end
        end
      end
      STEP_END: begin
        if (step_q + STEP_W'(1) == num_steps_q) begin
          state_d = DONE;
        end else begin
          step_d  = step_q + STEP_W'(1);
          j_d     = '0;
          state_d = FETCH;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      j_q         <= '0;
      step_q      <= '0;
      num_steps_q <= '0;
      init_vol_q  <= '0;
      csr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      step_q      <= step_d;
      num_steps_q <= num_steps_d;
      init_vol_q  <= init_vol_d;
      csr_err_q   <= csr_err_d;
    end
  end

  csr_row_walker #(
    .OFFSET_W (OFFSET_W),
    .W_ADDR_W (W_ADDR_W)
  ) u_row_walker (
    .clk            (clk),
    .rst            (rst),
    .row_go         (row_go),
    .row_end_in     (off_set_value),
    .row_clear      (row_clear),
    .row_done       (row_done),
    .err_set        (err_set),
    .load_voltage   (load_voltage),
    .w_n_a_valid    (w_n_a_valid),
    .CSR_w_addr     (CSR_w_addr),
    .export_voltage (export_voltage)
  );

  assign offset_mem_addr = (state_q inside {INIT, FETCH, LATCH, LOAD}) ? j_q : '0;
  assign vol_mem_control       = (state_q == INIT);
  assign init_mem_vol          = vol_mem_control ? init_vol_q : '0;
  assign current_step_finished = (state_q == STEP_END);
  assign step_idx              = step_q;
  assign busy                  = (state_q != IDLE);
  assign all_done              = (state_q == DONE);
  assign csr_err               = csr_err_q;

endmodule

// File: tb/tb_csr_layer_controller_param.sv
// tb_csr_layer_controller_param
//   Drives a 4-neuron controller against an offset memory model. Every run's
//   expected cycle-by-cycle output trace is generated up front from the layer
//   rules: init writes, then per neuron fetch, latch, load, nnz weights and
//   export, then the step end and the done pulse. Each cycle is checked
//   against that trace.
module tb_csr_layer_controller_param;

  localparam int N  = 4;
  localparam int NW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_steps;
  logic [15:0] init_vol;
  logic [9:0]  off_set_value;
  logic [NW-1:0] offset_mem_addr;
  logic [13:0] CSR_w_addr;
  logic        w_n_a_valid, load_voltage, export_voltage, vol_mem_control;
  logic [15:0] init_mem_vol;
  logic        current_step_finished, busy, all_done, csr_err;
  logic [7:0]  step_idx;

  typedef struct packed {
    logic          vmc;
    logic [NW-1:0] addr;
    logic [15:0]   ivol;
    logic          valid;
    logic [13:0]   waddr;
    logic          load;
    logic          exp;
    logic          fin;
    logic [7:0]    step;
    logic          busy;
    logic          done;
    logic          err;
  } obs_t;

  obs_t       obs;
  obs_t       exp_q[$];
  logic [9:0] offs[N];
  logic       model_err;
  logic [7:0] model_step;
  int         checks = 0;
  int         errors = 0;

  csr_layer_controller_param #(.N_NEURONS(N)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .num_steps             (num_steps),
    .init_vol              (init_vol),
    .off_set_value         (off_set_value),
    .offset_mem_addr       (offset_mem_addr),
    .CSR_w_addr            (CSR_w_addr),
    .w_n_a_valid           (w_n_a_valid),
    .load_voltage          (load_voltage),
    .export_voltage        (export_voltage),
    .vol_mem_control       (vol_mem_control),
    .init_mem_vol          (init_mem_vol),
    .current_step_finished (current_step_finished),
    .step_idx              (step_idx),
    .busy                  (busy),
    .all_done              (all_done),
    .csr_err               (csr_err)
  );

  always #5 clk = ~clk;

  // Offset memory with one cycle of read latency
  always @(posedge clk) off_set_value <= offs[offset_mem_addr];

  always_comb obs = {vol_mem_control, offset_mem_addr, init_mem_vol, w_n_a_valid,
                     CSR_w_addr, load_voltage, export_voltage, current_step_finished,
                     step_idx, busy, all_done, csr_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input obs_t o, input obs_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  function automatic obs_t base();
    obs_t r;
    r      = '0;
    r.busy = 1'b1;
    r.step = model_step;
    r.err  = model_err;
    return r;
  endfunction

  // Expected trace for one accepted start, from the first INIT cycle up to
  // and including the IDLE cycle after DONE
  task automatic gen_run(input int ns, input logic [15:0] iv);
    obs_t r;
    int   rs, re;
    model_step = 8'd0;
    for (int j = 0; j < N; j++) begin
      r = base(); r.vmc = 1'b1; r.addr = NW'(j); r.ivol = iv; exp_q.push_back(r);
    end
    for (int s = 0; s < ns; s++) begin
      model_step = 8'(s);
      rs = 0;
      for (int j = 0; j < N; j++) begin
        r = base(); r.addr = NW'(j);
        exp_q.push_back(r);
        exp_q.push_back(r);
        re = int'(offs[j]);
        if (re < rs) begin
          model_err = 1'b1;
          re = rs;
        end
        r = base(); r.addr = NW'(j); r.load = 1'b1; exp_q.push_back(r);
        for (int a = rs; a < re; a++) begin
          r = base(); r.addr = NW'(j); r.valid = 1'b1; r.waddr = 14'(a); exp_q.push_back(r);
        end
        r = base(); r.addr = NW'(j); r.exp = 1'b1; exp_q.push_back(r);
        rs = re;
      end
      r = base(); r.fin = 1'b1; exp_q.push_back(r);
    end
    r = base(); r.done = 1'b1; exp_q.push_back(r);
    r = base(); r.busy = 1'b0; exp_q.push_back(r);
  endtask

  // Accept one start and check every cycle of the run; optionally pulse start
  // in the first ROW cycle and in DONE, where it must be ignored
  task automatic apply_stimulus(input string tag, input int ns, input logic [15:0] iv,
                                input int gap, input bit inject);
    obs_t e;
    int   idx, last_fin, first_fin, n_fin, n_done;
    bit   injected;
    exp_q.delete();
    gen_run(ns, iv);
    num_steps = 8'(ns);
    init_vol  = iv;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    num_steps = 8'($urandom);
    init_vol  = 16'($urandom);
    idx = 0; last_fin = -1; first_fin = -1; n_fin = 0; n_done = 0; injected = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output(tag, obs, e);
      if (current_step_finished) begin
        if (gap > 0 && last_fin >= 0) check_int({tag, "_step_gap"}, idx - last_fin, gap);
        if (first_fin < 0) first_fin = idx;
        last_fin = idx;
        n_fin++;
      end
      if (all_done) begin
        n_done++;
        if (ns > 0) check_int({tag, "_done_after_fin"}, idx - last_fin, 1);
      end
      start = inject && ((e.valid && !injected) || e.done);
      if (e.valid) injected = 1'b1;
      tick();
      start = 1'b0;
      idx++;
    end
    if (gap > 0) check_int({tag, "_first_fin"}, first_fin, N + gap - 1);
    check_int({tag, "_fin_count"}, n_fin, ns);
    check_int({tag, "_done_count"}, n_done, 1);
  endtask

  initial begin
    obs_t e;
    int   acc;
    bit   hit;
    rst = 1'b1; start = 1'b0; num_steps = '0; init_vol = '0;
    model_err = 1'b0; model_step = 8'd0;
    offs = '{10'd0, 10'd0, 10'd0, 10'd0};
    repeat (3) tick();
    rst = 1'b0;
    check_output("reset_state", obs, obs_t'(0));

    // Reset asserted during the third weight of row 1
    offs = '{10'd2, 10'd6, 10'd7, 10'd8};
    exp_q.delete();
    gen_run(1, 16'h0042);
    num_steps = 8'd1; init_vol = 16'h0042; start = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0;
    while (exp_q.size() > 0 && !hit) begin
      e = exp_q.pop_front();
      check_output("pre_reset", obs, e);
      if (e.valid && e.addr == NW'(1) && e.waddr == 14'd4) hit = 1'b1;
      else tick();
    end
    check_int("rst_mid_row_reached", int'(hit), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_err = 1'b0; model_step = 8'd0;
    check_output("rst_mid_row", obs, obs_t'(0));

    offs = '{10'd3, 10'd3, 10'd7, 10'd8};
    apply_stimulus("one_step", 1, 16'h0100, 25, 1'b0);
    apply_stimulus("three_steps", 3, 16'h0100, 25, 1'b1);
    apply_stimulus("zero_steps", 0, 16'h0BEE, 0, 1'b0);

    offs = '{10'd5, 10'd2, 10'd6, 10'd6};
    apply_stimulus("malformed", 1, 16'h0007, 0, 1'b0);
    offs = '{10'd1, 10'd2, 10'd3, 10'd4};
    apply_stimulus("err_sticky", 1, 16'h0008, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_err = 1'b0; model_step = 8'd0;
    check_output("err_cleared", obs, obs_t'(0));

    for (int k = 0; k < 4; k++) begin
      acc = 0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 4) == 0 && acc > 0) begin
          offs[i] = 10'(acc - 1);
        end else begin
          acc += $urandom_range(0, 3);
          offs[i] = 10'(acc);
        end
      end
      apply_stimulus("random", $urandom_range(1, 3), 16'($urandom), 0, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
